// File: rtl/cart_bus_pkg.sv
// Shared constants and types for the DMG cartridge bus initiator.
package cart_bus_pkg;

    localparam int unsigned PHASE_W = 3;
    typedef logic [PHASE_W-1:0] phase_t;

    // Bus-cycle phase numbering and the strobe windows built from it
    localparam phase_t PH_ADDR      = 3'd0;
    localparam phase_t PH_SEL_FIRST = 3'd1;
    localparam phase_t PH_RD_FIRST  = 3'd1;
    localparam phase_t PH_OE_FIRST  = 3'd2;
    localparam phase_t PH_WR_FIRST  = 3'd3;
    localparam phase_t PH_WR_LAST   = 3'd6;
    localparam phase_t PH_SEL_LAST  = 3'd6;
    localparam phase_t PH_CAPTURE   = 3'd6;
    localparam phase_t PH_END       = 3'd7;

    localparam logic [15:0] RAM_LO = 16'hA000;
    localparam logic [15:0] RAM_HI = 16'hFDFF;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] adr;
        logic [7:0]  wdata;
    } bus_req_t;

    function automatic logic in_window(input phase_t ph, input phase_t lo, input phase_t hi);
        return (ph >= lo) && (ph <= hi);
    endfunction

    function automatic logic is_ram(input logic [15:0] adr);
        return (adr >= RAM_LO) && (adr <= RAM_HI);
    endfunction

endpackage

// File: rtl/cart_bus_phase_gen.sv
// Sub-phase divider and 3-bit phase counter pacing one cartridge bus cycle.
module cart_bus_phase_gen
    import cart_bus_pkg::*;
#(
    parameter int unsigned PHASE_DIV = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   run,
    output phase_t phase,
    output logic   phase_last,
    output logic   pre_last,
    output logic   cycle_end
);

    localparam int unsigned SUB_W = $clog2(PHASE_DIV);

    logic [SUB_W-1:0] sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub   <= '0;
            phase <= PH_ADDR;
        end else if (start) begin
            sub   <= '0;
            phase <= PH_ADDR;
        end else if (run) begin
            if (phase_last) begin
                sub   <= '0;
                phase <= phase + 3'(1);
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

    // pre_last lets the master register req_ready for the last clk of phase 7
    assign phase_last = (sub == SUB_W'(PHASE_DIV - 1));
    assign pre_last   = (sub == SUB_W'(PHASE_DIV - 2));
    assign cycle_end  = run && phase_last && (phase == PH_END);

endmodule

// File: rtl/cart_bus_master.sv
// CPU-side initiator for the DMG cartridge bus; one read or write per bus cycle.
// Optional CART_BUS_STATS_EN adds completed read/write counters.
module cart_bus_master
    import cart_bus_pkg::*;
#(
    parameter int unsigned PHASE_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_adr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [14:0] adr_out,
    output logic        n_a15,
    output logic        n_cs,
    output logic        n_rd,
    output logic        n_wr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
`ifdef CART_BUS_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e   state, state_nxt;
    bus_req_t cur, cur_nxt;
    phase_t   phase, ph_nxt;
    logic     phase_last, pre_last, cycle_end;
    logic     accept, running;
    logic [7:0] rd_cap;

    assign running = (state == RUN);

    cart_bus_phase_gen #(
        .PHASE_DIV (PHASE_DIV)
    ) u_phase_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (accept),
        .run        (running),
        .phase      (phase),
        .phase_last (phase_last),
        .pre_last   (pre_last),
        .cycle_end  (cycle_end)
    );

    // Next state, latched request and next phase; outputs are registered from these
    always_comb begin
        accept    = req_valid && req_ready;
        state_nxt = state;
        cur_nxt   = cur;
        ph_nxt    = phase;
        if (accept) begin
            state_nxt     = RUN;
            cur_nxt.op    = req_write ? OP_WR : OP_RD;
            cur_nxt.adr   = req_adr;
            cur_nxt.wdata = req_wdata;
            ph_nxt        = PH_ADDR;
        end else if (cycle_end) begin
            state_nxt = IDLE;
        end else if (running && phase_last) begin
            ph_nxt = phase + 3'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            rd_cap    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            adr_out   <= '0;
            n_a15     <= 1'b1;
            n_cs      <= 1'b1;
            n_rd      <= 1'b1;
            n_wr      <= 1'b1;
            data_out  <= '0;
            data_oe   <= 1'b0;
`ifdef CART_BUS_STATS_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            req_ready <= (state_nxt == IDLE) ||
                         (!accept && running && (phase == PH_END) && pre_last);
            adr_out   <= cur_nxt.adr[14:0];
            data_out  <= cur_nxt.wdata;
            n_a15     <= 1'b1;
            n_cs      <= 1'b1;
            n_rd      <= 1'b1;
            n_wr      <= 1'b1;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;

            if (state_nxt == RUN) begin
                if (in_window(ph_nxt, PH_SEL_FIRST, PH_SEL_LAST)) begin
                    n_a15 <= cur_nxt.adr[15];
                    n_cs  <= !is_ram(cur_nxt.adr);
                end
                if (cur_nxt.op == OP_RD) begin
                    n_rd <= !in_window(ph_nxt, PH_RD_FIRST, PH_END);
                end else begin
                    data_oe <= in_window(ph_nxt, PH_OE_FIRST, PH_END);
                    n_wr    <= !in_window(ph_nxt, PH_WR_FIRST, PH_WR_LAST);
                end
            end

            // Pad register already delays data_in by one clk
            if (running && (cur.op == OP_RD) && (phase == PH_CAPTURE) && phase_last) begin
                rd_cap <= data_in;
            end

            if (cycle_end && (cur.op == OP_RD)) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rd_cap;
            end

`ifdef CART_BUS_STATS_EN
            if (cycle_end && (cur.op == OP_RD)) rd_count <= rd_count + 16'(1);
            if (cycle_end && (cur.op == OP_WR)) wr_count <= wr_count + 16'(1);
`endif
        end
    end

endmodule

// File: tb/tb_cart_bus_master.sv
// Scoreboard bench for cart_bus_master with a registered-pad cartridge model.
module tb_cart_bus_master;

    localparam int unsigned PD  = 8;
    localparam int unsigned CYC = 8 * PD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_adr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [14:0] adr_out;
    logic        n_a15, n_cs, n_rd, n_wr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
`ifdef CART_BUS_STATS_EN
    logic [15:0] rd_count, wr_count;
    bit          preload = 1'b0;
`endif

    cart_bus_master #(
        .PHASE_DIV (PD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .adr_out   (adr_out),
        .n_a15     (n_a15),
        .n_cs      (n_cs),
        .n_rd      (n_rd),
        .n_wr      (n_wr),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in)
`ifdef CART_BUS_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] cart_byte(input logic [15:0] a);
        if (a == 16'h0100) return 8'hC3;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Cartridge drives the bus while n_rd is low; pad register adds one clk
    always @(posedge clk) data_in <= !n_rd ? cart_byte({n_a15, adr_out}) : 8'hFF;

    typedef struct {
        int unsigned t;
        logic [7:0]  d;
    } rsp_t;
    rsp_t q[$];

    int unsigned last_rsp_t = 0;
    int unsigned prev_rsp_t = 0;

    // Monitor: per-clk strobe model, response scoreboard, counters
    initial begin
        bit          act;
        int unsigned k_start;
        logic        wr_op;
        logic [15:0] t_adr;
        logic [7:0]  t_wd;
        logic [14:0] exp_adr;
        logic [15:0] exp_rd, exp_wr;
        bit          inw;
        int unsigned p;
        logic        ea15, ecs, erd, ewr, eoe, erdy;
        rsp_t        r;
        act = 0; k_start = 0; wr_op = 0; t_adr = '0; t_wd = '0;
        exp_adr = '0; exp_rd = '0; exp_wr = '0;
        forever begin
            @(negedge clk);
`ifdef CART_BUS_STATS_EN
            if (preload) exp_rd = 16'hFFFF;
`endif
            inw = act && (cyc > k_start) && (cyc <= k_start + CYC);
            ea15 = 1; ecs = 1; erd = 1; ewr = 1; eoe = 0; erdy = 1;
            if (inw) begin
                p    = (cyc - k_start - 1) / PD;
                erdy = (cyc == k_start + CYC);
                if (p >= 1 && p <= 6) begin
                    ea15 = t_adr[15];
                    ecs  = !(t_adr >= 16'hA000 && t_adr <= 16'hFDFF);
                end
                erd = !(!wr_op && p >= 1);
                ewr = !(wr_op && p >= 3 && p <= 6);
                eoe = wr_op && p >= 2;
            end
            chk("strobes", 32'({n_a15, n_cs, n_rd, n_wr, data_oe}), 32'({ea15, ecs, erd, ewr, eoe}));
            chk("req_ready", 32'(req_ready), 32'(erdy));
            chk("adr_out", 32'(adr_out), 32'(exp_adr));
            if (eoe) chk("data_out", 32'(data_out), 32'(t_wd));
`ifdef CART_BUS_STATS_EN
            chk("rd_count", 32'(rd_count), 32'(exp_rd));
            chk("wr_count", 32'(wr_count), 32'(exp_wr));
`endif
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(1), 32'(0));
                end else begin
                    r = q.pop_front();
                    chk("rsp_time", cyc, r.t);
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.d));
                    prev_rsp_t = last_rsp_t;
                    last_rsp_t = cyc;
                end
            end else if (q.size() > 0 && q[0].t <= cyc) begin
                chk("rsp_missing", 32'(0), 32'(1));
                void'(q.pop_front());
            end

            if (rst) begin
                act = 0;
                q.delete();
                exp_adr = '0;
                exp_rd = '0;
                exp_wr = '0;
            end else begin
                if (inw && cyc == k_start + CYC) begin
                    if (wr_op) exp_wr = exp_wr + 16'(1);
                    else       exp_rd = exp_rd + 16'(1);
                end
                if (req_valid && req_ready) begin
                    act     = 1;
                    k_start = cyc;
                    wr_op   = req_write;
                    t_adr   = req_adr;
                    t_wd    = req_wdata;
                    exp_adr = req_adr[14:0];
                    if (!req_write) q.push_back('{cyc + CYC + 1, cart_byte(req_adr)});
                end
            end
        end
    end

    // Present a request and hold it until accepted; k = negedge count of the handshake
    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         output int unsigned k);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_adr   = a;
        req_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 300);
        if (!req_ready) chk("accept_timeout", 32'(0), 32'(1));
        k = cyc;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (CYC + 4) @(posedge clk);
        #2;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k1, k2;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_adr_out", 32'(adr_out), 32'(0));
        chk("rst_strobes", 32'({n_a15, n_cs, n_rd, n_wr}), 32'(4'b1111));
        chk("rst_data", 32'({data_out, data_oe}), 32'(0));
        @(posedge clk);
        #2;

        // ROM read returning 0xC3
        issue(1'b0, 16'h0100, 8'h00, k1);
        wait_idle();

        // External RAM write
        issue(1'b1, 16'hA000, 8'h5A, k1);
        wait_idle();

        // Back-to-back reads with the request held valid
        issue(1'b0, 16'h0000, 8'h00, k1);
        issue(1'b0, 16'h0001, 8'h00, k2);
        chk("b2b_gap", k2 - k1, CYC);
        wait_idle();
        chk("rsp_spacing", last_rsp_t - prev_rsp_t, CYC);

        // A15 high, outside RAM window
        issue(1'b0, 16'h8000, 8'h00, k1);
        wait_idle();

        // Reset in phase 4 of a RAM write
        issue(1'b1, 16'hC123, 8'hA5, k1);
        repeat (4 * PD + 1) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_n_wr", 32'(n_wr), 32'(1));
        chk("abort_oe", 32'(data_oe), 32'(0));
        chk("abort_ready", 32'(req_ready), 32'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Recovery read after the abort
        issue(1'b0, 16'h4000, 8'h00, k1);
        wait_idle();

`ifdef CART_BUS_STATS_EN
        // Counter wrap from a preloaded 0xFFFF
        force dut.rd_count = 16'hFFFF;
        preload = 1'b1;
        @(posedge clk);
        #2;
        release dut.rd_count;
        preload = 1'b0;
        issue(1'b0, 16'h0123, 8'h00, k1);
        wait_idle();
        chk("rd_wrap", 32'(rd_count), 32'(0));
`endif

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
